// File: rtl/usb_reg_sequencer.sv
// Host-visible configuration register file: assembles per-byte writes into atomic
// register commits and streams register snapshots to the USB transmit path.
module usb_reg_sequencer #(
  parameter int NUM_REGS  = 4,
  parameter int REG_BYTES = 4,
  parameter int REG_W     = 8 * REG_BYTES
) (
  input  logic                      clk_usb,
  input  logic                      reset_n,
  input  logic [7:0]                reg_cmd,
  input  logic [15:0]               reg_bytecount,
  input  logic [7:0]                reg_data_in,
  input  logic                      reg_write,
  input  logic                      rd_start,
  input  logic [5:0]                rd_addr,
  input  logic [15:0]               rd_len,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      rd_busy,
  output logic                      rd_done,
  output logic [NUM_REGS*REG_W-1:0] cfg_out,
  output logic [NUM_REGS-1:0]       cfg_update,
  output logic                      cmd_err,
  input  logic                      err_clr
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [6:0]  NREG_7  = 7'(NUM_REGS);
  localparam logic [15:0] NBYTE_16 = 16'(REG_BYTES);

  logic [REG_W-1:0] shadow_r [NUM_REGS];
  logic [REG_W-1:0] shadow_s [NUM_REGS];
  logic [REG_W-1:0] cfg_r    [NUM_REGS];
  logic [REG_W-1:0] cfg_s    [NUM_REGS];
  logic [NUM_REGS-1:0] upd_s, upd_r;

  logic [5:0]  wr_addr_s;
  logic [15:0] wr_idx_s;
  logic        wr_ok_s, wr_last_s, wr_err_s;

  state_t           state_r, state_s;
  logic [15:0]      cnt_r, cnt_s, len_r, len_s;
  logic [REG_W-1:0] snap_r, snap_s, rd_sel_s;
  logic             rd_addr_ok_s, done_s, rd_err_s;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r, rd_busy_r, rd_done_r, err_r;

  // Lanes beyond the register width read back as zero padding.
  function automatic logic [7:0] lane_sel(input logic [REG_W-1:0] v, input logic [15:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < REG_BYTES; b++) begin
      if (i == 16'(b)) r = v[8*b +: 8];
      else r = r;
    end
    return r;
  endfunction

  assign wr_addr_s = reg_cmd[5:0];
  assign wr_idx_s  = reg_bytecount - 16'd1;
  assign wr_ok_s   = reg_write && (reg_bytecount != 16'd0) && ({1'b0, wr_addr_s} < NREG_7)
                     && (wr_idx_s < NBYTE_16);
  assign wr_last_s = wr_ok_s && (wr_idx_s == NBYTE_16 - 16'd1);
  assign wr_err_s  = reg_write && !wr_ok_s;

  // Shadow byte merge and commit; the committed value includes the byte of this cycle.
  always_comb begin
    shadow_s = shadow_r;
    cfg_s    = cfg_r;
    upd_s    = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_ok_s && (wr_addr_s == 6'(k))) begin
        for (int b = 0; b < REG_BYTES; b++) begin
          if (wr_idx_s == 16'(b)) shadow_s[k][8*b +: 8] = reg_data_in;
          else shadow_s[k][8*b +: 8] = shadow_r[k][8*b +: 8];
        end
        if (wr_last_s) begin
          cfg_s[k] = shadow_s[k];
          upd_s[k] = 1'b1;
        end else begin
          cfg_s[k] = cfg_r[k];
          upd_s[k] = 1'b0;
        end
      end else begin
        shadow_s[k] = shadow_r[k];
        cfg_s[k]    = cfg_r[k];
        upd_s[k]    = 1'b0;
      end
    end
  end

  // Read-address decode against the committed (pre-commit this cycle) registers.
  always_comb begin
    rd_sel_s     = '0;
    rd_addr_ok_s = ({1'b0, rd_addr} < NREG_7);
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == 6'(k)) rd_sel_s = cfg_r[k];
      else rd_sel_s = rd_sel_s;
    end
  end

  // Read stream next-state logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    len_s    = len_r;
    snap_s   = snap_r;
    done_s   = 1'b0;
    rd_err_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rd_start) begin
          rd_err_s = !rd_addr_ok_s;
          if (rd_len == 16'd0) begin
            done_s = 1'b1;
          end else begin
            state_s = S_SEND;
            cnt_s   = 16'd0;
            len_s   = rd_len;
            snap_s  = rd_addr_ok_s ? rd_sel_s : '0;
          end
        end else begin
          rd_err_s = 1'b0;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (cnt_r == len_r - 16'd1) begin
            state_s = S_IDLE;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_usb) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_r[k] <= '0;
        cfg_r[k]    <= '0;
      end
      upd_r      <= '0;
      state_r    <= S_IDLE;
      cnt_r      <= 16'd0;
      len_r      <= 16'd0;
      snap_r     <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      rd_busy_r  <= 1'b0;
      rd_done_r  <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      shadow_r   <= shadow_s;
      cfg_r      <= cfg_s;
      upd_r      <= upd_s;
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      len_r      <= len_s;
      snap_r     <= snap_s;
      tx_data_r  <= (state_s == S_SEND) ? lane_sel(snap_s, cnt_s) : 8'h00;
      tx_valid_r <= (state_s == S_SEND);
      rd_busy_r  <= (state_s == S_SEND);
      rd_done_r  <= done_s;
      err_r      <= (wr_err_s || rd_err_s) ? 1'b1 : (err_clr ? 1'b0 : err_r);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_out[g*REG_W +: REG_W] = cfg_r[g];
  end

  assign cfg_update = upd_r;
  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign rd_busy    = rd_busy_r;
  assign rd_done    = rd_done_r;
  assign cmd_err    = err_r;

endmodule

// File: tb/tb_usb_reg_sequencer.sv
// Directed bench for usb_reg_sequencer: a byte-array/queue model predicts every output each
// cycle, and literal expectations pin the headline scenarios.
module tb_usb_reg_sequencer;
  localparam int NR = 4;
  localparam int RB = 4;

  logic         clk_usb = 1'b0, reset_n = 1'b0;
  logic [7:0]   reg_cmd = 8'h00, reg_data_in = 8'h00;
  logic [15:0]  reg_bytecount = 16'd0, rd_len = 16'd0;
  logic         reg_write = 1'b0, rd_start = 1'b0, tx_ready = 1'b0, err_clr = 1'b0;
  logic [5:0]   rd_addr = 6'd0;
  logic [7:0]   tx_data;
  logic         tx_valid, rd_busy, rd_done, cmd_err;
  logic [127:0] cfg_out;
  logic [3:0]   cfg_update;

  always #5 clk_usb = ~clk_usb;

  usb_reg_sequencer dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .reg_cmd(reg_cmd), .reg_bytecount(reg_bytecount),
    .reg_data_in(reg_data_in), .reg_write(reg_write), .rd_start(rd_start), .rd_addr(rd_addr),
    .rd_len(rd_len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rd_busy(rd_busy), .rd_done(rd_done), .cfg_out(cfg_out), .cfg_update(cfg_update),
    .cmd_err(cmd_err), .err_clr(err_clr)
  );

  int n_tests = 0, n_fail = 0;
  logic [7:0] m_shadow [NR][RB];
  logic [7:0] m_cfg    [NR][RB];
  logic [3:0] m_upd = 4'b0;
  logic       m_err = 1'b0, m_done = 1'b0;
  logic [7:0] m_q[$];
  logic [7:0] cap[$];
  int         done_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_cfg();
    logic [127:0] e;
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < RB; b++) e[r*32 + b*8 +: 8] = m_cfg[r][b];
    return e;
  endfunction

  // One clock edge of the model, using the inputs the DUT samples on the same edge.
  task automatic model_step();
    logic err_set;
    int a, bc;
    err_set = 1'b0;
    if (!reset_n) begin
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < RB; b++) begin
          m_shadow[r][b] = 8'h00;
          m_cfg[r][b] = 8'h00;
        end
      m_q.delete();
      m_upd = 4'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_q.size() > 0) begin
        if (tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1'b1;
        end
      end else if (rd_start) begin
        if (rd_addr >= NR) err_set = 1'b1;
        if (rd_len == 16'd0) m_done = 1'b1;
        for (int i = 0; i < int'(rd_len); i++)
          m_q.push_back((i < RB && rd_addr < NR) ? m_cfg[rd_addr][i] : 8'h00);
      end
      m_upd = 4'b0;
      a  = int'(reg_cmd[5:0]);
      bc = int'(reg_bytecount);
      if (reg_write) begin
        if (bc == 0 || bc > RB || a >= NR) err_set = 1'b1;
        else begin
          m_shadow[a][bc-1] = reg_data_in;
          if (bc == RB) begin
            for (int b = 0; b < RB; b++) m_cfg[a][b] = m_shadow[a][b];
            m_upd[a] = 1'b1;
          end
        end
      end
      if (err_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  endtask

  task automatic tick();
    if (tx_valid && tx_ready) cap.push_back(tx_data);
    @(posedge clk_usb);
    model_step();
    @(negedge clk_usb);
    chk("tx_valid", tx_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("tx_data", tx_data, m_q[0]);
    chk("rd_busy", rd_busy, m_q.size() > 0);
    chk("rd_done", rd_done, m_done);
    chk("cfg_out", cfg_out, exp_cfg());
    chk("cfg_update", cfg_update, m_upd);
    chk("cmd_err", cmd_err, m_err);
    if (rd_done) done_cnt++;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] d);
    reg_cmd = {2'b00, a}; reg_bytecount = bc; reg_data_in = d; reg_write = 1'b1;
    tick();
  endtask

  task automatic idle();
    reg_write = 1'b0; rd_start = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget && done_cnt == 0; i++) tick();
    if (done_cnt == 0) chk("rd_done_timeout", 1'b0, 1'b1);
  endtask

  task automatic cap_chk(input string nm, input int n, input logic [63:0] e);
    chk({nm, "_len"}, cap.size(), n);
    for (int i = 0; i < n && i < cap.size(); i++) chk(nm, cap[i], e[8*i +: 8]);
  endtask

  initial begin
    tick(); tick();
    chk("reset_cfg", cfg_out, 128'h0);
    chk("reset_err", cmd_err, 1'b0);
    reset_n = 1'b1;
    tick();

    for (int i = 1; i <= 4; i++) wr(6'd1, 16'(i), 8'(8'h11 * i));
    chk("wr1_cfg", cfg_out, {64'h0, 32'h44332211, 32'h0});
    chk("wr1_upd", cfg_update, 4'b0010);
    idle(); tick();
    chk("wr1_upd_clear", cfg_update, 4'b0000);

    for (int i = 1; i <= 3; i++) wr(6'd2, 16'(i), 8'(i));
    idle(); tick();
    chk("partial_cfg", cfg_out[95:64], 32'h0);
    wr(6'd2, 16'd1, 8'hDD); wr(6'd2, 16'd2, 8'hCC); wr(6'd2, 16'd3, 8'hBB); wr(6'd2, 16'd4, 8'hAA);
    idle(); tick();
    chk("wr2_cfg", cfg_out[95:64], 32'hAABBCCDD);

    for (int i = 1; i <= 5; i++) wr(6'd0, 16'(i), 8'(8'h0F + i));
    idle(); tick();
    chk("over_cfg", cfg_out[31:0], 32'h13121110);
    chk("over_err", cmd_err, 1'b1);
    err_clr = 1'b1; tick(); idle();
    chk("err_clr", cmd_err, 1'b0);
    wr(6'd7, 16'd1, 8'h5A); idle();
    chk("bad_addr_err", cmd_err, 1'b1);
    chk("bad_addr_upd", cfg_update, 4'b0000);
    err_clr = 1'b1; tick();
    wr(6'd7, 16'd1, 8'h5A); idle();
    chk("err_set_vs_clr", cmd_err, 1'b1);
    err_clr = 1'b1; tick(); idle();
    wr(6'd1, 16'd0, 8'h77); idle(); tick();
    chk("bc0_err", cmd_err, 1'b1);
    err_clr = 1'b1; tick(); idle(); tick();

    cap.delete(); done_cnt = 0;
    rd_start = 1'b1; rd_addr = 6'd1; rd_len = 16'd6; tx_ready = 1'b0;
    tick(); idle();
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      tx_ready = (i % 2 == 0);
      rd_start = (i == 2); rd_addr = 6'd2; rd_len = 16'd3;
      tick();
    end
    idle(); tx_ready = 1'b0;
    tick(); tick();
    cap_chk("stream", 6, 64'h0000_0000_4433_2211);
    chk("stream_done_cnt", done_cnt, 1);

    rd_start = 1'b1; rd_addr = 6'd1; rd_len = 16'd0;
    tick(); idle();
    chk("len0_done", rd_done, 1'b1);
    chk("len0_valid", tx_valid, 1'b0);
    tick();
    chk("len0_done_drop", rd_done, 1'b0);

    cap.delete(); done_cnt = 0; tx_ready = 1'b1;
    wr(6'd1, 16'd1, 8'hA1); wr(6'd1, 16'd2, 8'hA2); wr(6'd1, 16'd3, 8'hA3);
    rd_start = 1'b1; rd_addr = 6'd1; rd_len = 16'd4;
    wr(6'd1, 16'd4, 8'hA4); idle();
    wait_done(20);
    cap_chk("precommit", 4, 64'h4433_2211);
    chk("commit_after_snap", cfg_out[63:32], 32'hA4A3A2A1);

    cap.delete(); done_cnt = 0;
    rd_start = 1'b1; rd_addr = 6'd9; rd_len = 16'd2;
    tick(); idle();
    wait_done(10);
    cap_chk("bad_rd", 2, 64'h0);
    chk("bad_rd_err", cmd_err, 1'b1);

    done_cnt = 0; tx_ready = 1'b0;
    rd_start = 1'b1; rd_addr = 6'd2; rd_len = 16'd4;
    tick(); idle();
    wr(6'd3, 16'd1, 8'h01); wr(6'd3, 16'd2, 8'h02); idle();
    reset_n = 1'b0; tick();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_busy", rd_busy, 1'b0);
    chk("rst_cfg", cfg_out, 128'h0);
    chk("rst_err", cmd_err, 1'b0);
    reset_n = 1'b1; tick(); tick();
    chk("rst_no_done", done_cnt, 0);
    wr(6'd3, 16'd4, 8'h99); idle(); tick();
    chk("rst_shadow", cfg_out[127:96], 32'h9900_0000);

    cap.delete(); done_cnt = 0; tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) wr(6'd3, 16'(i), 8'(8'h44 + 8'h11 * i));
    idle();
    rd_start = 1'b1; rd_addr = 6'd3; rd_len = 16'd5;
    tick(); idle();
    wait_done(20);
    cap_chk("post_rst", 5, 64'h00_8877_6655);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
